ahfp_mul_multi: RTL and testbench

AHFP_MUL_MULTI -- requirements
Module: ahfp_mul_multi

---
 rtl/ahfp_mul_multi.sv | 155 +++++++++++++++
 tb/tb_ahfp_mul_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ahfp_mul_multi.sv
// Three-stage pipelined IEEE-754 binary32 multiplier with flush-to-zero inputs and outputs,
// round-to-nearest-even, and a registered result. A new operand pair is accepted every cycle.
module ahfp_mul_multi (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Exponent field 0 is flushed to zero, so denormals never reach the mantissa path.
    function automatic cls_e classify(input logic [7:0] exp_f, input logic [22:0] frac_f);
        cls_e c;
        if (exp_f == 8'h00) begin
            c = CLS_ZERO;
        end else if (exp_f == 8'hFF) begin
            c = (frac_f != 23'd0) ? CLS_NAN : CLS_INF;
        end else begin
            c = CLS_NUM;
        end
        return c;
    endfunction

    // Stage 1 registers: unpacked operand fields
    logic        s1_sign_q;
    logic [7:0]  s1_ea_q;
    logic [7:0]  s1_eb_q;
    logic [22:0] s1_fa_q;
    logic [22:0] s1_fb_q;

    // Stage 2 registers: raw product, unnormalised exponent, sign and class
    logic [47:0]       s2_prod_q;
    logic signed [9:0] s2_exp_q;
    logic              s2_sign_q;
    cls_e              s2_cls_q;

    // Stage 3 register
    logic [31:0] result_q;

    // Stage 2 next-state
    logic [47:0]       s2_prod_d;
    logic signed [9:0] s2_exp_d;
    cls_e              s2_cls_d;
    cls_e              cls_a_s;
    cls_e              cls_b_s;

    // Stage 2: mantissa product, exponent sum and special-case classification
    always_comb begin
        cls_a_s   = classify(s1_ea_q, s1_fa_q);
        cls_b_s   = classify(s1_eb_q, s1_fb_q);
        s2_prod_d = {1'b1, s1_fa_q} * {1'b1, s1_fb_q};
        s2_exp_d  = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - 10'sd127;
        if ((cls_a_s == CLS_NAN) || (cls_b_s == CLS_NAN) ||
            ((cls_a_s == CLS_ZERO) && (cls_b_s == CLS_INF)) ||
            ((cls_a_s == CLS_INF) && (cls_b_s == CLS_ZERO))) begin
            s2_cls_d = CLS_NAN;
        end else if ((cls_a_s == CLS_INF) || (cls_b_s == CLS_INF)) begin
            s2_cls_d = CLS_INF;
        end else if ((cls_a_s == CLS_ZERO) || (cls_b_s == CLS_ZERO)) begin
            s2_cls_d = CLS_ZERO;
        end else begin
            s2_cls_d = CLS_NUM;
        end
    end

    // Stage 3 next-state
    logic [22:0]       mant_s;
    logic              guard_s;
    logic              sticky_s;
    logic              round_up_s;
    logic [24:0]       rnd_sum_s;
    logic [22:0]       frac_s;
    logic signed [9:0] exp_norm_s;
    logic signed [9:0] exp_fin_s;
    logic [31:0]       result_d;

    // Stage 3: normalise, round to nearest even, range-check and pack
    always_comb begin
        if (s2_prod_q[47]) begin
            mant_s     = s2_prod_q[46:24];
            guard_s    = s2_prod_q[23];
            sticky_s   = |s2_prod_q[22:0];
            exp_norm_s = s2_exp_q + 10'sd1;
        end else begin
            mant_s     = s2_prod_q[45:23];
            guard_s    = s2_prod_q[22];
            sticky_s   = |s2_prod_q[21:0];
            exp_norm_s = s2_exp_q;
        end
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        rnd_sum_s  = {2'b01, mant_s} + {24'd0, round_up_s};
        // A carry out of the rounded mantissa means it became exactly 2.0.
        if (rnd_sum_s[24]) begin
            frac_s    = rnd_sum_s[23:1];
            exp_fin_s = exp_norm_s + 10'sd1;
        end else begin
            frac_s    = rnd_sum_s[22:0];
            exp_fin_s = exp_norm_s;
        end
        case (s2_cls_q)
            CLS_NAN:  result_d = QNAN;
            CLS_INF:  result_d = {s2_sign_q, 8'hFF, 23'd0};
            CLS_ZERO: result_d = {s2_sign_q, 31'd0};
            CLS_NUM: begin
                if (exp_fin_s >= 10'sd255) begin
                    result_d = {s2_sign_q, 8'hFF, 23'd0};
                end else if (exp_fin_s <= 10'sd0) begin
                    result_d = {s2_sign_q, 31'd0};
                end else begin
                    result_d = {s2_sign_q, exp_fin_s[7:0], frac_s};
                end
            end
            default:  result_d = QNAN;
        endcase
    end

    // Pipeline registers; reset clears every stage so no in-flight product survives
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_sign_q <= 1'b0;
            s1_ea_q   <= 8'd0;
            s1_eb_q   <= 8'd0;
            s1_fa_q   <= 23'd0;
            s1_fb_q   <= 23'd0;
            s2_prod_q <= 48'd0;
            s2_exp_q  <= 10'sd0;
            s2_sign_q <= 1'b0;
            s2_cls_q  <= CLS_NUM;
            result_q  <= 32'd0;
        end else begin
            s1_sign_q <= dataa[31] ^ datab[31];
            s1_ea_q   <= dataa[30:23];
            s1_eb_q   <= datab[30:23];
            s1_fa_q   <= dataa[22:0];
            s1_fb_q   <= datab[22:0];
            s2_prod_q <= s2_prod_d;
            s2_exp_q  <= s2_exp_d;
            s2_sign_q <= s1_sign_q;
            s2_cls_q  <= s2_cls_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ahfp_mul_multi.sv
// Self-checking bench for ahfp_mul_multi: directed vector table, hand-written reset
// sequences, and a randomized stream checked against an integer-arithmetic reference.
module tb_ahfp_mul_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    ahfp_mul_multi dut (
        .clk    (clk),
        .reset  (reset),
        .dataa  (dataa),
        .datab  (datab),
        .result (result)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    logic [31:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, req);
        end
    endtask

    // Reference: exact integer product, then round-to-nearest-even on the discarded bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic            s;
        int              ea, eb, e, sh;
        bit              az, ai, an, bz, bi, bn;
        longint unsigned p, m, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        if (an || bn || (az && bi) || (ai && bz)) return 32'h7FC0_0000;
        if (ai || bi) return {s, 8'hFF, 23'd0};
        if (az || bz) return {s, 31'd0};
        p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e = ea + eb - 127;
        sh = ((p >> 47) != 64'd0) ? 24 : 23;
        if (sh == 24) e++;
        m    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if ((rem > half) || ((rem == half) && ((m & 64'd1) != 64'd0))) m++;
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(m)};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] ex;
        case ($urandom_range(0, 9))
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            2, 3:    ex = 8'($urandom_range(190, 254));
            4:       ex = 8'($urandom_range(1, 70));
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), ex, ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom)};
    endfunction

    // Drive one pair per cycle; compare the pair launched three cycles earlier.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] y, input string nm);
        @(negedge clk);
        if (exp_q.size() == 3) check(name_q.pop_front(), result, exp_q.pop_front());
        dataa = a;
        datab = b;
        exp_q.push_back(y);
        name_q.push_back(nm);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) push_pair(32'd0, 32'd0, 32'd0, "flush");
        exp_q.delete();
        name_q.delete();
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{32'h00000000, 32'h3F800000, 32'h00000000};
        tbl[1]  = '{32'h3F800000, 32'h40000000, 32'h40000000};
        tbl[2]  = '{32'h40000000, 32'h40800000, 32'h41000000};
        tbl[3]  = '{32'h40400000, 32'h40600000, 32'h41280000};
        tbl[4]  = '{32'h43FA0000, 32'h41133333, 32'h458FC000};
        tbl[5]  = '{32'h41EC0000, 32'h453BF800, 32'h47AD48A0};
        tbl[6]  = '{32'h42FF999A, 32'h42FCCCCD, 32'h467C67AF};
        tbl[7]  = '{32'h46A5E51F, 32'h435FAB85, 32'h4A90F1BC};
        tbl[8]  = '{32'h4640E400, 32'h47F12040, 32'h4EB5AEF1};
        tbl[9]  = '{32'h3F8E363B, 32'h3AA137F4, 32'h3AB31E61};
        tbl[10] = '{32'hBF800000, 32'h40000000, 32'hC0000000};
        tbl[11] = '{32'h80000000, 32'h3F800000, 32'h80000000};
        tbl[12] = '{32'h7F800000, 32'h3F800000, 32'h7F800000};
        tbl[13] = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
        tbl[14] = '{32'h7FC00000, 32'h12345678, 32'h7FC00000};
        tbl[15] = '{32'h7F000000, 32'h40000000, 32'h7F800000};
        tbl[16] = '{32'h00800000, 32'h00800000, 32'h00000000};

        // Reset state and first-product latency after release
        reset = 1'b1;
        dataa = 32'h3F800000;
        datab = 32'h40000000;
        repeat (2) @(negedge clk);
        check("reset_state", result, 32'h00000000);
        reset = 1'b0;
        dataa = 32'h40000000;
        datab = 32'h40800000;
        @(negedge clk);
        check("post_reset_lat1", result, 32'h00000000);
        dataa = 32'd0;
        datab = 32'd0;
        @(negedge clk);
        check("post_reset_lat2", result, 32'h00000000);
        @(negedge clk);
        check("post_reset_first", result, 32'h41000000);

        // Directed table, streamed back-to-back
        foreach (tbl[i]) push_pair(tbl[i].a, tbl[i].b, tbl[i].y, $sformatf("vec%0d", i));
        drain();

        // Reset with a full pipeline
        push_pair(32'h40400000, 32'h40600000, 32'h41280000, "pre_rst0");
        push_pair(32'h3F800000, 32'h40000000, 32'h40000000, "pre_rst1");
        push_pair(32'h40000000, 32'h40800000, 32'h41000000, "pre_rst2");
        exp_q.delete();
        name_q.delete();
        @(negedge clk);
        reset = 1'b1;
        dataa = 32'h43FA0000;
        datab = 32'h41133333;
        @(negedge clk);
        check("reset_mid", result, 32'h00000000);
        reset = 1'b0;
        dataa = 32'd0;
        datab = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("no_stale%0d", i), result, 32'h00000000);
        end

        // Randomized stream against the reference
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = rand_op();
            b = rand_op();
            push_pair(a, b, ref_mul(a, b), $sformatf("rnd%0d_%08h_%08h", i, a, b));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
